// File: rtl/apb_cop_fifo_pkg.sv
// cop_fifo_pkg: register word offsets, STATUS/CTRL bit positions and the STATUS layout
package cop_fifo_pkg;

    localparam logic [9:0] WORD_TXDATA = 10'd0;
    localparam logic [9:0] WORD_RXDATA = 10'd1;
    localparam logic [9:0] WORD_STATUS = 10'd2;
    localparam logic [9:0] WORD_CTRL   = 10'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_OVF      = 4;
    localparam int ST_UDF      = 5;
    localparam int ST_TX_CNT   = 8;
    localparam int ST_RX_CNT   = 16;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_FLUSH  = 1;

    localparam int CNT_W = 8;

    // Packed view of STATUS, MSB first, so field positions match the bit constants above
    typedef struct packed {
        logic [7:0]       rsvd_hi;
        logic [CNT_W-1:0] rx_count;
        logic [CNT_W-1:0] tx_count;
        logic [1:0]       rsvd_lo;
        logic             udf;
        logic             ovf;
        logic             rx_empty;
        logic             rx_full;
        logic             tx_empty;
        logic             tx_full;
    } status_t;

endpackage

// File: rtl/apb_cop_fifo_if.sv
// apb_cop_fifo_if: APB slave signals plus the TX/RX core streams of the coprocessor front-end
interface apb_cop_fifo_if #(
    parameter int vnapbslv = 16
);

    logic [0:vnapbslv-1] vpsel;
    logic                vpenable;
    logic [31:0]         vpaddr;
    logic                vpwrite;
    logic [31:0]         vpwdata;
    logic [31:0]         vprdata;
    logic                tx_valid;
    logic [31:0]         tx_data;
    logic                tx_ready;
    logic                rx_valid;
    logic [31:0]         rx_data;
    logic                rx_ready;

    modport slave (
        input  vpsel, vpenable, vpaddr, vpwrite, vpwdata, tx_ready, rx_valid, rx_data,
        output vprdata, tx_valid, tx_data, rx_ready
    );

    modport master (
        output vpsel, vpenable, vpaddr, vpwrite, vpwdata, tx_ready, rx_valid, rx_data,
        input  vprdata, tx_valid, tx_data, rx_ready
    );

endinterface

// File: rtl/apb_cop_fifo_sync_fifo.sv
// cop_sync_fifo: synchronous FIFO, no fall-through, full/empty judged on start-of-cycle state
module cop_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Pointer/count next state; pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_d  = flush_i ? '0 : wr_q + AW'(do_push);
        rd_d  = flush_i ? '0 : rd_q + AW'(do_pop);
        cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer/count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers alone decide which entries are live
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/apb_cop_fifo.sv
// apb_cop_fifo: APB register front-end with TX/RX FIFOs to a coprocessor; COP_FIFO_IRQ_EN adds the irq output
module apb_cop_fifo #(
    parameter int vpindex  = 8,
    parameter int vnapbslv = 16,
    parameter int DEPTH    = 8
) (
    input  logic          vclk,
    input  logic          vrst,
    apb_cop_fifo_if.slave bus
`ifdef COP_FIFO_IRQ_EN
    ,
    output logic          irq
`endif
);

    import cop_fifo_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic        sel, wr_acc, rd_acc, flush, st_wr, ctrl_wr;
    logic [9:0]  word;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [AW:0] tx_cnt, rx_cnt;
    logic [31:0] rx_head;
    logic        ovf_q, ovf_d, udf_q, udf_d, irq_en;
    status_t     status;
    logic        unused;

    assign sel     = bus.vpsel[vpindex] & bus.vpenable;
    assign word    = bus.vpaddr[11:2];
    assign wr_acc  = sel & bus.vpwrite;
    assign rd_acc  = sel & ~bus.vpwrite;
    assign st_wr   = wr_acc && word == WORD_STATUS;
    assign ctrl_wr = wr_acc && word == WORD_CTRL;
    assign flush   = ctrl_wr & bus.vpwdata[CTRL_FLUSH];
    assign unused  = ^{bus.vpaddr[31:12], bus.vpaddr[1:0], bus.vpsel};

    assign bus.tx_valid = ~tx_empty;
    assign bus.rx_ready = ~rx_full;

    cop_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx (
        .clk     (vclk),
        .rst     (vrst),
        .push_i  (wr_acc && word == WORD_TXDATA),
        .pop_i   (bus.tx_ready),
        .flush_i (flush),
        .data_i  (bus.vpwdata),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_cnt),
        .head_o  (bus.tx_data)
    );

    cop_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx (
        .clk     (vclk),
        .rst     (vrst),
        .push_i  (bus.rx_valid),
        .pop_i   (rd_acc && word == WORD_RXDATA),
        .flush_i (flush),
        .data_i  (bus.rx_data),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_cnt),
        .head_o  (rx_head)
    );

    // Sticky error flags: flush clears them, a new error beats a same-cycle W1C
    always_comb begin
        ovf_d = flush ? 1'b0 : (ovf_q & ~(st_wr & bus.vpwdata[ST_OVF])) | (wr_acc && word == WORD_TXDATA && tx_full);
        udf_d = flush ? 1'b0 : (udf_q & ~(st_wr & bus.vpwdata[ST_UDF])) | (rd_acc && word == WORD_RXDATA && rx_empty);
    end

    // Sticky flag registers
    always_ff @(posedge vclk) begin
        if (vrst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

`ifdef COP_FIFO_IRQ_EN
    logic irq_en_q, irq_en_d;

    // Interrupt enable is rewritten by every CTRL write
    always_comb begin
        irq_en_d = ctrl_wr ? bus.vpwdata[CTRL_IRQ_EN] : irq_en_q;
    end

    // Interrupt enable register
    always_ff @(posedge vclk) begin
        if (vrst) irq_en_q <= 1'b0;
        else      irq_en_q <= irq_en_d;
    end

    assign irq_en = irq_en_q;
    assign irq    = irq_en_q & (~rx_empty | ovf_q | udf_q);
`else
    assign irq_en = 1'b0;
`endif

    // STATUS word assembled from FIFO flags, counts and sticky errors
    always_comb begin
        status          = '0;
        status.tx_full  = tx_full;
        status.tx_empty = tx_empty;
        status.rx_full  = rx_full;
        status.rx_empty = rx_empty;
        status.ovf      = ovf_q;
        status.udf      = udf_q;
        status.tx_count = CNT_W'(tx_cnt);
        status.rx_count = CNT_W'(rx_cnt);
    end

    assign bus.vprdata = !sel                 ? '0 :
                         word == WORD_RXDATA  ? (rx_empty ? '0 : rx_head) :
                         word == WORD_STATUS  ? status :
                         word == WORD_CTRL    ? {31'b0, irq_en} : '0;

endmodule

// File: tb/tb_apb_cop_fifo.sv
// tb_apb_cop_fifo: directed literal checks plus randomized traffic against a queue-based model
module tb_apb_cop_fifo;

    localparam int DEPTH = 8;
    localparam int IDX   = 8;
    localparam int NS    = 16;

    logic vclk = 1'b0;
    logic vrst;
    always #5 vclk = ~vclk;

    apb_cop_fifo_if #(.vnapbslv(NS)) bus ();

`ifdef COP_FIFO_IRQ_EN
    logic irq;
`endif

    apb_cop_fifo #(.vpindex(IDX), .vnapbslv(NS), .DEPTH(DEPTH)) dut (
        .vclk (vclk),
        .vrst (vrst),
        .bus  (bus)
`ifdef COP_FIFO_IRQ_EN
        ,
        .irq  (irq)
`endif
    );

    logic [31:0] txm[$];
    logic [31:0] rxm[$];
    bit ovfm, udfm, ienm, armed;
    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] status_m();
        int v;
        v = rxm.size() * 65536 + txm.size() * 256 + int'(udfm) * 32 + int'(ovfm) * 16
          + (rxm.size() == 0 ? 8 : 0) + (rxm.size() == DEPTH ? 4 : 0)
          + (txm.size() == 0 ? 2 : 0) + (txm.size() == DEPTH ? 1 : 0);
        return 32'(v);
    endfunction

    function automatic logic [31:0] rd_m(input int w);
        if (w == 1) return rxm.size() > 0 ? rxm[0] : 32'h0;
        if (w == 2) return status_m();
        if (w == 3) return {31'b0, ienm};
        return 32'h0;
    endfunction

    always @(posedge vclk) begin : mdl
        bit s, wr, fl, txp, rxp, txpush, rxpop, tx_ok, rx_ok;
        int w;
        logic [31:0] wd;
        if (vrst) begin
            txm.delete();
            rxm.delete();
            ovfm = 0;
            udfm = 0;
            ienm = 0;
            armed = 1;
        end else if (armed) begin
            s  = bus.vpsel[IDX] && bus.vpenable;
            wr = bus.vpwrite;
            w  = int'(bus.vpaddr[11:2]);
            wd = bus.vpwdata;
            fl = s && wr && w == 3 && wd[1];
`ifdef COP_FIFO_IRQ_EN
            if (s && wr && w == 3) ienm = wd[0];
`endif
            if (fl) begin
                txm.delete();
                rxm.delete();
                ovfm = 0;
                udfm = 0;
            end else begin
                txp    = txm.size() > 0 && bus.tx_ready;
                rxp    = bus.rx_valid && rxm.size() < DEPTH;
                txpush = s && wr && w == 0;
                rxpop  = s && !wr && w == 1;
                tx_ok  = txm.size() < DEPTH;
                rx_ok  = rxm.size() > 0;
                if (s && wr && w == 2) begin
                    if (wd[4]) ovfm = 0;
                    if (wd[5]) udfm = 0;
                end
                if (txpush && !tx_ok) ovfm = 1;
                if (rxpop && !rx_ok) udfm = 1;
                if (txp) void'(txm.pop_front());
                if (txpush && tx_ok) txm.push_back(wd);
                if (rxpop && rx_ok) void'(rxm.pop_front());
                if (rxp) rxm.push_back(bus.rx_data);
            end
        end
    end

    always @(negedge vclk) begin : cmp
        bit s;
        if (armed) begin
            s = bus.vpsel[IDX] && bus.vpenable;
            chk("tx_valid", {31'b0, bus.tx_valid}, {31'b0, txm.size() > 0});
            if (txm.size() > 0) chk("tx_data", bus.tx_data, txm[0]);
            chk("rx_ready", {31'b0, bus.rx_ready}, {31'b0, rxm.size() < DEPTH});
            if (!(s && bus.vpwrite)) chk("vprdata", bus.vprdata, s ? rd_m(int'(bus.vpaddr[11:2])) : 32'h0);
`ifdef COP_FIFO_IRQ_EN
            chk("irq", {31'b0, irq}, {31'b0, ienm && (rxm.size() > 0 || ovfm || udfm)});
`endif
        end
    end

    task automatic idle();
        bus.vpsel    = '0;
        bus.vpenable = 1'b0;
        bus.vpwrite  = 1'b0;
        bus.vpaddr   = '0;
        bus.vpwdata  = '0;
    endtask

    task automatic access(input logic wr, input logic [9:0] w, input logic [31:0] d);
        bus.vpsel      = '0;
        bus.vpsel[IDX] = 1'b1;
        bus.vpenable   = 1'b1;
        bus.vpwrite    = wr;
        bus.vpaddr     = {20'h0, w, 2'b00};
        bus.vpwdata    = d;
    endtask

    task automatic bus_wr(input logic [9:0] w, input logic [31:0] d);
        access(1'b1, w, d);
        @(posedge vclk);
        #1;
        idle();
    endtask

    task automatic bus_rd(input logic [9:0] w, output logic [31:0] d);
        access(1'b0, w, 32'h0);
        @(negedge vclk);
        d = bus.vprdata;
        @(posedge vclk);
        #1;
        idle();
    endtask

    task automatic rd_chk(input string nm, input logic [9:0] w, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(w, d);
        chk(nm, d, exp);
    endtask

    task automatic drain_chk(input string nm, input int n, input logic [31:0] base);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge vclk);
            chk({nm, "_valid"}, {31'b0, bus.tx_valid}, 32'h1);
            chk({nm, "_data"}, bus.tx_data, base + 32'(i));
        end
        @(negedge vclk);
        chk({nm, "_end"}, {31'b0, bus.tx_valid}, 32'h0);
        @(posedge vclk);
        #1;
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [9:0]  w;
        int tx_p, rx_p;
        vrst         = 1'b1;
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        idle();
        repeat (2) @(posedge vclk);
        #1;
        vrst = 1'b0;

        rd_chk("status_reset", 10'd2, 32'h0000_000A);
        chk("rx_ready_reset", {31'b0, bus.rx_ready}, 32'h1);
        chk("tx_valid_reset", {31'b0, bus.tx_valid}, 32'h0);

        bus_wr(10'd0, 32'h11);
        bus_wr(10'd0, 32'h22);
        bus_wr(10'd0, 32'h33);
        rd_chk("status_tx3", 10'd2, 32'h0000_0308);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge vclk);
            chk("tx_seq", bus.tx_data, 32'h11 * 32'(i + 1));
        end
        @(negedge vclk);
        chk("tx_seq_end", {31'b0, bus.tx_valid}, 32'h0);
        @(posedge vclk);
        #1;
        bus.tx_ready = 1'b0;

        for (int i = 0; i <= DEPTH; i++) bus_wr(10'd0, 32'h100 + 32'(i));
        rd_chk("status_ovf", 10'd2, 32'h0000_0819);
        bus_wr(10'd2, 32'h10);
        rd_chk("status_ovf_w1c", 10'd2, 32'h0000_0809);
        drain_chk("tx_full_drain", DEPTH, 32'h100);

        rd_chk("rx_empty_read", 10'd1, 32'h0);
        rd_chk("status_udf", 10'd2, 32'h0000_002A);
        bus.rx_data  = 32'hCAFE_BABE;
        bus.rx_valid = 1'b1;
        @(posedge vclk);
        #1;
        bus.rx_valid = 1'b0;
        rd_chk("rx_cafe", 10'd1, 32'hCAFE_BABE);
        rd_chk("status_rx_popped", 10'd2, 32'h0000_002A);
        bus_wr(10'd2, 32'h20);
        rd_chk("status_udf_w1c", 10'd2, 32'h0000_000A);

        bus.rx_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.rx_data = 32'd200 + 32'(i);
            @(posedge vclk);
            #1;
        end
        bus.rx_valid = 1'b0;
        rd_chk("status_rx_full", 10'd2, 32'h0008_0006);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 32'hDEAD;
        rd_chk("rx_full_pop", 10'd1, 32'd200);
        bus.rx_valid = 1'b0;
        rd_chk("status_rx_refused", 10'd2, 32'h0007_0002);
        for (int i = 1; i < DEPTH; i++) rd_chk("rx_drain", 10'd1, 32'd200 + 32'(i));

        for (int i = 0; i < DEPTH / 2; i++) bus_wr(10'd0, 32'h50 + 32'(i));
        rd_chk("status_tx_half", 10'd2, 32'h0000_0408);
        bus_wr(10'd3, 32'h2);
        rd_chk("status_flush", 10'd2, 32'h0000_000A);
        rd_chk("ctrl_flush", 10'd3, 32'h0);

`ifdef COP_FIFO_IRQ_EN
        bus_wr(10'd3, 32'h1);
        @(negedge vclk);
        chk("irq_empty", {31'b0, irq}, 32'h0);
        bus.rx_data  = 32'h55;
        bus.rx_valid = 1'b1;
        @(posedge vclk);
        #1;
        bus.rx_valid = 1'b0;
        @(negedge vclk);
        chk("irq_rx", {31'b0, irq}, 32'h1);
        rd_chk("irq_pop", 10'd1, 32'h55);
        @(negedge vclk);
        chk("irq_clear", {31'b0, irq}, 32'h0);
        rd_chk("ctrl_irq_en", 10'd3, 32'h1);
`endif

        bus_wr(10'd0, 32'hA1);
        bus_wr(10'd0, 32'hA2);
        vrst         = 1'b1;
        bus.rx_valid = 1'b1;
        bus.tx_ready = 1'b1;
        @(posedge vclk);
        #1;
        vrst         = 1'b0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        rd_chk("status_mid_reset", 10'd2, 32'h0000_000A);

        for (int c = 0; c < 4000; c++) begin
            tx_p = ((c / 400) % 2 == 0) ? 10 : 90;
            rx_p = ((c / 300) % 2 == 0) ? 85 : 15;
            vrst = ($urandom_range(0, 399) == 0);
            bus.vpsel = NS'($urandom);
            if ($urandom_range(0, 4) != 0) bus.vpsel[IDX] = 1'b1;
            bus.vpenable = $urandom_range(0, 5) != 0;
            bus.vpwrite  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 9))
                0, 1, 2: w = 10'd0;
                3, 4:    w = 10'd1;
                5, 6:    w = 10'd2;
                7:       w = 10'd3;
                8:       w = 10'($urandom_range(4, 1023));
                default: w = 10'd1;
            endcase
            r = $urandom;
            bus.vpaddr  = {r[31:12], w, r[1:0]};
            bus.vpwdata = $urandom;
            if (w == 10'd3) bus.vpwdata[1] = ($urandom_range(0, 15) == 0);
            bus.tx_ready = $urandom_range(0, 99) < tx_p;
            bus.rx_valid = $urandom_range(0, 99) < rx_p;
            bus.rx_data  = $urandom;
            @(posedge vclk);
            #1;
        end
        vrst = 1'b0;
        idle();
        @(posedge vclk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
